weight_load_sched: RTL

Sequencer for the weight FIFO path. Accepts a load command naming a base address and a tile count, then for each tile:
- reads SYS_ROW consecutive weight rows from the weight SRAM,
- times the FIFO writes against the SRAM read latency,
- waits for the systolic array to request the tile,
- pulses the FIFO output controller and waits for its done.

It sits between the command/control unit and the weight SRAM, the weight FIFO write port and the FIFO output controller.

---
 rtl/weight_load_sched.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/weight_load_sched.sv
// weight_load_sched
// Sequences weight tiles from the weight SRAM into the weight FIFO. Each
// tile is SYS_ROW consecutive rows. The FIFO write strobe trails the SRAM
// reads by RD_LAT cycles. The tile is held until the systolic array asks
// for it, and then the FIFO output controller is started.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   cmd_valid_i/_ready_o load command handshake
//   cmd_base_addr_i      SRAM address of row 0, tile 0
//   cmd_num_tiles_i      number of tiles to load (0 = complete at once)
//   sram_ren_o/raddr_o   SRAM read port
//   fifo_wr_o            weight FIFO write strobe (read data valid)
//   drain_req_i          array ready to take the next tile
//   out_en_o/out_done_i  output controller start pulse / completion
//   busy_o               not idle
//   tile_done_o          one pulse per completed tile
//   all_done_o           one pulse per completed command
//
// state    | meaning
// IDLE     | ready for a command
// FILL     | issuing SYS_ROW row reads for the current tile
// WAIT_LAT | letting the last RD_LAT reads land in the FIFO
// READY    | tile buffered, waiting for drain_req
// DRAIN    | output controller started, waiting for out_done
module weight_load_sched #(
  parameter int SYS_ROW        = 16,
  parameter int ADDR_WIDTH     = 12,
  parameter int RD_LAT         = 2,
  parameter int TILE_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]     cmd_base_addr_i,
  input  logic [TILE_CNT_WIDTH-1:0] cmd_num_tiles_i,
  output logic                      sram_ren_o,
  output logic [ADDR_WIDTH-1:0]     sram_raddr_o,
  output logic                      fifo_wr_o,
  input  logic                      drain_req_i,
  output logic                      out_en_o,
  input  logic                      out_done_i,
  output logic                      busy_o,
  output logic                      tile_done_o,
  output logic                      all_done_o
);

  localparam int ROW_W = $clog2(SYS_ROW) + 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {IDLE, FILL, WAIT_LAT, READY, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [TILE_CNT_WIDTH-1:0] tile_q, tile_d, tile_nxt;
  logic [TILE_CNT_WIDTH-1:0] num_q, num_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [RD_LAT-1:0]         lat_pipe_q;
  logic [ADDR_WIDTH-1:0]     sram_raddr_q, raddr_d;
  logic                      sram_ren_q, ren_d;
  logic                      cmd_ready_q, busy_q;
  logic                      out_en_q, out_en_d;
  logic                      tile_done_q, tile_done_d;
  logic                      all_done_q, all_done_d;

  assign tile_nxt = tile_q + TILE_CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    tile_d      = tile_q;
    num_d       = num_q;
    lat_d       = lat_q;
    raddr_d     = sram_raddr_q;
    ren_d       = 1'b0;
    out_en_d    = 1'b0;
    tile_done_d = 1'b0;
    all_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          num_d  = cmd_num_tiles_i;
          tile_d = '0;
          row_d  = '0;
          if (cmd_num_tiles_i != '0) begin
            state_d = FILL;
            ren_d   = 1'b1;
            raddr_d = cmd_base_addr_i;
          end else begin
            all_done_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (row_q == ROW_W'(SYS_ROW - 1)) begin
          state_d = WAIT_LAT;
          row_d   = '0;
          lat_d   = LAT_W'(RD_LAT - 1);
        end else begin
          row_d   = row_q + ROW_W'(1);
          ren_d   = 1'b1;
          raddr_d = sram_raddr_q + ADDR_WIDTH'(1);
        end
      end
      WAIT_LAT: begin
        if (lat_q == '0) state_d = READY;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      READY: begin
        if (drain_req_i) begin
          state_d  = DRAIN;
          out_en_d = 1'b1;
        end
      end
      DRAIN: begin
        // out_en_q marks the first DRAIN cycle; a done there is not credible.
        if (out_done_i && !out_en_q) begin
          tile_done_d = 1'b1;
          tile_d      = tile_nxt;
          if (tile_nxt == num_q) begin
            state_d    = IDLE;
            all_done_d = 1'b1;
          end else begin
            // Tiles are contiguous, so the next tile's row 0 directly follows
            // the last row read, i.e. base + tile_idx*SYS_ROW.
            state_d = FILL;
            ren_d   = 1'b1;
            raddr_d = sram_raddr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      row_q        <= '0;
      tile_q       <= '0;
      num_q        <= '0;
      lat_q        <= '0;
      lat_pipe_q   <= '0;
      sram_raddr_q <= '0;
      sram_ren_q   <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      out_en_q     <= 1'b0;
      tile_done_q  <= 1'b0;
      all_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      tile_q       <= tile_d;
      num_q        <= num_d;
      lat_q        <= lat_d;
      lat_pipe_q   <= (lat_pipe_q << 1) | RD_LAT'(sram_ren_q);
      sram_raddr_q <= raddr_d;
      sram_ren_q   <= ren_d;
      cmd_ready_q  <= (state_d == IDLE);
      busy_q       <= (state_d != IDLE);
      out_en_q     <= out_en_d;
      tile_done_q  <= tile_done_d;
      all_done_q   <= all_done_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign busy_o       = busy_q;
  assign sram_ren_o   = sram_ren_q;
  assign sram_raddr_o = sram_raddr_q;
  assign fifo_wr_o    = lat_pipe_q[RD_LAT-1];
  assign out_en_o     = out_en_q;
  assign tile_done_o  = tile_done_q;
  assign all_done_o   = all_done_q;

endmodule
